// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux select.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    // state   | meaning
    // FETCH   | read instruction at PC, PC+4 (IR/PC load once mem_ready)
    // DECODE  | register read, branch target precompute, opcode dispatch
    // MEMADR  | effective address A + signext(imm)
    // MEMRD   | data memory read, waits for mem_ready
    // MEMWB   | MDR -> rt
    // MEMWR   | data memory write, waits for mem_ready
    // EXECUTE | R-type ALU operation
    // ALUWB   | ALUOut -> rd
    // BRANCH  | compare A/B, load PC from ALUOut if zero
    // ADDIEX  | A + signext(imm)
    // ADDIWB  | ALUOut -> rt
    // JUMP    | load PC with jump target

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // PC and IR load only on the cycle the fetch completes
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // reset holds every strobe low regardless of the registered state
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
        end
    end

    assign state      = rst_n ? 4'(state_q) : 4'd0;
    assign illegal_op = rst_n & illegal_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode held in the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables, muxes and the 2-bit alu_op that feeds the ALU control decoder directly downstream.
- Handshakes with instruction/data memory through mem_ready.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE onward
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
reg_write  out  1  register file write
reg_dst  out  1  dest reg: 1=rd, 0=rt
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct decode (to ALU control)
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
state  out  4  current state encoding (debug)
illegal_op  out  1  1-cycle pulse on undecodable opcode

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH.
- Reset: on a rising clk with rst_n=0, state<=FETCH and illegal_op<=0. While rst_n=0, all control outputs are forced to 0 combinationally and state reads 0. Reset overrides any pending transition or memory wait.
- Outputs are Moore outputs decoded from state; the exception is FETCH gating by mem_ready. Any signal not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, pc_write=ir_write=mem_ready. Holds until mem_ready=1, then goes to DECODE. This gating ensures the PC increments exactly once per fetch.
- DECODE: alu_src_b=11 (branch target precompute). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other -> FETCH, with illegal_op<=1 for the next cycle only
- MEMADR: alu_src_a=1, alu_src_b=10. Next state: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds while mem_ready=0, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds while mem_ready=0, then goes to FETCH.
- EXECUTE: alu_src_a=1, alu_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
- ADDIWB: reg_write=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- Cycle counts with mem_ready held at 1:
  - LW = 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB)
  - SW = 4
  - R-type = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- illegal_op is registered: it is set only on the DECODE->FETCH illegal transition and cleared on the next clock.

Test Plan:
1. rst_n=0 for 2 cycles with opcode=6'b100011 and mem_ready=1 -> state=0 and all outputs 0 throughout; after release, first cycle shows FETCH with mem_read=1, pc_write=1, ir_write=1, alu_src_b=01.
2. LW (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0. MEMRD shows mem_read=1, i_or_d=1; MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
3. R-type (000000) -> state sequence 0,1,6,7,0. EXECUTE shows alu_op=10, alu_src_a=1; ALUWB shows reg_write=1, reg_dst=1.
4. BEQ (000100) then J (000010) -> BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01; JUMP shows pc_write=1, pc_source=10. Each instruction takes 3 cycles.
5. SW (101011) with mem_ready=0 for 3 cycles in FETCH and 2 in MEMWR:
   - pc_write=0 while FETCH waits; it is 1 only in the cycle mem_ready=1.
   - mem_write stays 1 for 3 cycles.
   - Total 9 cycles.
6. opcode=6'b111111 -> DECODE goes to FETCH with illegal_op=1 for exactly one cycle. Separately, assert rst_n=0 while in MEMRD with mem_ready=0 -> next state FETCH and outputs 0 during reset.
